// File: rtl/joy_pkg.sv
// Shared constants and helpers for the joystick direction conditioner.
// Direction nibble layout is {up, down, left, right}; the highest bit has the highest priority.
package joy_pkg;

  localparam logic [1:0] JOY_8WAY = 2'd0;
  localparam logic [1:0] JOY_4NEW = 2'd1;
  localparam logic [1:0] JOY_4OLD = 2'd2;
  localparam logic [1:0] JOY_2H   = 2'd3;

  localparam int DIR_UP = 3;
  localparam int DIR_DN = 2;
  localparam int DIR_LT = 1;
  localparam int DIR_RT = 0;

  // Keeps only the highest-priority set bit; returns 0 for an empty input.
  function automatic logic [3:0] prio_onehot(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[DIR_UP])      r[DIR_UP] = 1'b1;
    else if (v[DIR_DN]) r[DIR_DN] = 1'b1;
    else if (v[DIR_LT]) r[DIR_LT] = 1'b1;
    else if (v[DIR_RT]) r[DIR_RT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit vector debounce: a bit follows its input only after it has differed
// for DEB_TICKS consecutive ce ticks. DEB_TICKS=0 degenerates to a plain register.
module joy_debounce #(
  parameter int WIDTH     = 4,
  parameter int DEB_TICKS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEB_TICKS == 0) begin : g_bypass
      logic unused_ce;
      assign unused_ce = ce;

      always_ff @(posedge clk) begin
        if (reset) dout <= '0;
        else       dout <= din;
      end
    end else begin : g_count
      localparam int CW = $clog2(DEB_TICKS + 1);
      localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

      logic [CW-1:0] cnt [WIDTH];

      // Counter restarts whenever the input agrees again, so short glitches never land.
      always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (reset) begin
            cnt[i]  <= '0;
            dout[i] <= 1'b0;
          end else if (din[i] == dout[i]) begin
            cnt[i] <= '0;
          end else if (ce) begin
            if (cnt[i] == LAST) begin
              dout[i] <= ~dout[i];
              cnt[i]  <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-channel joystick direction conditioner: sync, debounce, mode-dependent
// arbitration (8-way / 4-way newest / 4-way oldest / 2-way horizontal) and change strobe.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int DEB_TICKS    = 0,
  parameter bit SOCD_NEUTRAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [4*NCH-1:0] indir,
  output logic [4*NCH-1:0] outdir,
  output logic [NCH-1:0]   changed
);

  logic [4*NCH-1:0] sync_q;
  logic [4*NCH-1:0] deb;
  logic [4*NCH-1:0] deb_prev;
  logic [4*NCH-1:0] cur_q;
  logic [4*NCH-1:0] cur_nxt_v;
  logic [4*NCH-1:0] out_nxt_v;
  logic [1:0]       mode_q;
  logic             mode_chg;

  assign mode_chg = (mode != mode_q);

  joy_debounce #(
    .WIDTH     (4 * NCH),
    .DEB_TICKS (DEB_TICKS)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din   (sync_q),
    .dout  (deb)
  );

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [3:0] d;
      logic [3:0] r;
      logic [3:0] dm;
      logic [3:0] rm;
      logic [3:0] cur;
      logic [3:0] cur_nxt;
      logic [3:0] out_nxt;

      assign d   = deb[4*c +: 4];
      assign r   = d & ~deb_prev[4*c +: 4];
      assign cur = cur_q[4*c +: 4];
      // Horizontal-only mode arbitrates exactly like newest-wins on a masked view.
      assign dm  = (mode == JOY_2H) ? (d & 4'b0011) : d;
      assign rm  = (mode == JOY_2H) ? (r & 4'b0011) : r;

      always_comb begin
        cur_nxt = cur;
        out_nxt = '0;
        if (mode_chg) begin
          cur_nxt = '0;
        end else begin
          case (mode)
            JOY_8WAY: begin
              cur_nxt = '0;
              out_nxt = d;
              if (SOCD_NEUTRAL) begin
                if (d[DIR_UP] && d[DIR_DN]) begin
                  out_nxt[DIR_UP] = 1'b0;
                  out_nxt[DIR_DN] = 1'b0;
                end
                if (d[DIR_LT] && d[DIR_RT]) begin
                  out_nxt[DIR_LT] = 1'b0;
                  out_nxt[DIR_RT] = 1'b0;
                end
              end
            end
            JOY_4NEW, JOY_2H: begin
              if (rm != 4'b0000)              cur_nxt = prio_onehot(rm);
              else if ((cur & dm) == 4'b0000) cur_nxt = prio_onehot(dm);
              out_nxt = cur_nxt;
            end
            JOY_4OLD: begin
              if ((cur & d) == 4'b0000) cur_nxt = prio_onehot(d);
              out_nxt = cur_nxt;
            end
            default: begin
              cur_nxt = '0;
            end
          endcase
        end
      end

      assign cur_nxt_v[4*c +: 4] = cur_nxt;
      assign out_nxt_v[4*c +: 4] = out_nxt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      deb_prev <= '0;
      mode_q   <= '0;
      cur_q    <= '0;
      outdir   <= '0;
      changed  <= '0;
    end else begin
      sync_q   <= indir;
      deb_prev <= deb;
      mode_q   <= mode;
      cur_q    <= cur_nxt_v;
      outdir   <= out_nxt_v;
      for (int c = 0; c < NCH; c++) begin
        changed[c] <= (out_nxt_v[4*c +: 4] != outdir[4*c +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: directed table, hand-timed corner sequences and a
// randomized run against a behavioural model of the 2-channel, no-debounce instance.
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce_a, ce_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] indir_a, outdir_a;
  logic [1:0] changed_a;
  logic [3:0] indir_b, outdir_b;
  logic [0:0] changed_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(.NCH(2), .DEB_TICKS(0), .SOCD_NEUTRAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .ce(ce_a), .mode(mode_a),
    .indir(indir_a), .outdir(outdir_a), .changed(changed_a)
  );

  joy_dir_filter #(.NCH(1), .DEB_TICKS(4), .SOCD_NEUTRAL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .ce(ce_b), .mode(mode_b),
    .indir(indir_b), .outdir(outdir_b), .changed(changed_b)
  );

  // ---------------- reference model of dut_a ----------------
  logic [7:0] m_hist [3];
  logic [7:0] m_out;
  logic [3:0] m_cur [2];
  logic [1:0] m_mode, m_chg;

  function automatic logic [3:0] pick(input logic [3:0] v);
    for (int b = 3; b >= 0; b--) if (v[b]) return 4'(1 << b);
    return 4'b0000;
  endfunction

  // Advances the model across one clock edge using the inputs applied to it.
  // m_hist[0] = synced input, m_hist[1] = debounced, m_hist[2] = debounced last cycle.
  task automatic model_edge();
    logic [7:0] n_out;
    logic [1:0] n_chg;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_out = '0; m_chg = '0; m_mode = '0;
      m_cur[0] = '0; m_cur[1] = '0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      logic [3:0] d, r, o, keep;
      d = m_hist[1][4*c +: 4];
      r = d & ~m_hist[2][4*c +: 4];
      o = 4'b0000;
      if (mode_a != m_mode) begin
        m_cur[c] = 4'b0000;
      end else if (mode_a == 2'd0) begin
        o = d;
        if (d[3] && d[2]) o = o & 4'b0011;
        if (d[1] && d[0]) o = o & 4'b1100;
      end else if (mode_a == 2'd2) begin
        if ((m_cur[c] & d) == 0) m_cur[c] = pick(d);
        o = m_cur[c];
      end else begin
        keep = (mode_a == 2'd3) ? 4'b0011 : 4'b1111;
        if ((r & keep) != 0)               m_cur[c] = pick(r & keep);
        else if ((m_cur[c] & d & keep) == 0) m_cur[c] = pick(d & keep);
        o = m_cur[c];
      end
      n_out[4*c +: 4] = o;
      n_chg[c] = (o != m_out[4*c +: 4]);
    end
    m_out = n_out;
    m_chg = n_chg;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = indir_a;
    m_mode = mode_a;
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ce_b = (cyc % 4 == 0);
    ce_a = 1'($urandom_range(0, 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [3:0] in;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic seen;
    int   ticks, n;
    logic tick_now;

    reset = 1'b1; ce_a = 1'b0; ce_b = 1'b1;
    mode_a = 2'd1; mode_b = 2'd0;
    indir_a = '0; indir_b = '0;
    steps(3);
    check("reset_out_a", 32'(outdir_a), 0);
    check("reset_chg_a", 32'(changed_a), 0);
    check("reset_out_b", 32'(outdir_b), 0);
    reset = 1'b0;
    steps(4);

    // ---- table-driven settled behaviour on channel 0 ----
    tbl[0]  = '{2'd1, 4'b0010, 4'b0010};
    tbl[1]  = '{2'd1, 4'b1010, 4'b1000};
    tbl[2]  = '{2'd1, 4'b0010, 4'b0010};
    tbl[3]  = '{2'd1, 4'b0000, 4'b0000};
    tbl[4]  = '{2'd2, 4'b0001, 4'b0001};
    tbl[5]  = '{2'd2, 4'b1001, 4'b0001};
    tbl[6]  = '{2'd2, 4'b1000, 4'b1000};
    tbl[7]  = '{2'd0, 4'b1110, 4'b0010};
    tbl[8]  = '{2'd0, 4'b1001, 4'b1001};
    tbl[9]  = '{2'd3, 4'b1010, 4'b0010};
    tbl[10] = '{2'd3, 4'b1000, 4'b0000};
    tbl[11] = '{2'd1, 4'b0101, 4'b0100};
    tbl[12] = '{2'd1, 4'b0111, 4'b0010};
    tbl[13] = '{2'd1, 4'b0101, 4'b0100};
    tbl[14] = '{2'd1, 4'b0111, 4'b0010};
    tbl[15] = '{2'd1, 4'b1111, 4'b1000};
    for (int i = 0; i < 16; i++) begin
      mode_a  = tbl[i].mode;
      indir_a = {4'b0000, tbl[i].in};
      steps(6);
      check($sformatf("tbl%0d", i), 32'(outdir_a), 32'({4'b0000, tbl[i].exp}));
    end

    // ---- mode 1 exact latency and change strobes ----
    mode_a = 2'd1; indir_a = 8'h00; steps(6);
    indir_a = 8'h02; steps(2);
    check("lat_before", 32'(outdir_a), 0);
    step();
    check("lat_left", 32'(outdir_a), 32'h02);
    check("chg_left", 32'(changed_a), 1);
    step();
    check("chg_left_end", 32'(changed_a), 0);
    steps(9);
    indir_a = 8'h0A; steps(3);
    check("up_newest", 32'(outdir_a), 32'h08);
    check("chg_up", 32'(changed_a), 1);
    indir_a = 8'h02; steps(3);
    check("up_release", 32'(outdir_a), 32'h02);
    check("chg_up_rel", 32'(changed_a), 1);
    indir_a = 8'h00; steps(3);
    check("left_release", 32'(outdir_a), 0);
    check("chg_left_rel", 32'(changed_a), 1);

    // ---- mode 2 release timing ----
    mode_a = 2'd2; indir_a = 8'h01; steps(6);
    indir_a = 8'h09; steps(6);
    check("old_hold", 32'(outdir_a), 32'h01);
    indir_a = 8'h08; steps(2);
    check("old_rel_early", 32'(outdir_a), 32'h01);
    step();
    check("old_rel", 32'(outdir_a), 32'h08);

    // ---- mode change 1 -> 0 while holding down ----
    mode_a = 2'd1; indir_a = 8'h04; steps(6);
    check("dn_held", 32'(outdir_a), 32'h04);
    mode_a = 2'd0; step();
    check("mchg_zero", 32'(outdir_a), 0);
    check("mchg_chg0", 32'(changed_a), 1);
    step();
    check("mchg_back", 32'(outdir_a), 32'h04);
    check("mchg_chg1", 32'(changed_a), 1);

    // ---- reset while holding ----
    mode_a = 2'd1; indir_a = 8'h02; steps(6);
    reset = 1'b1; step();
    check("rst_hold_out", 32'(outdir_a), 0);
    check("rst_hold_chg", 32'(changed_a), 0);
    reset = 1'b0; steps(2);
    check("rst_reappear_early", 32'(outdir_a), 0);
    step();
    check("rst_reappear", 32'(outdir_a), 32'h02);

    // ---- two channels pressed together ----
    indir_a = 8'h00; steps(6);
    indir_a = 8'h81; steps(3);
    check("dual_out", 32'(outdir_a), 32'h81);
    check("dual_chg", 32'(changed_a), 3);

    // ---- debounce: short pulse rejected ----
    indir_b = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (outdir_b != 0) seen = 1'b1;
    end
    indir_b = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      step();
      if (outdir_b != 0) seen = 1'b1;
    end
    check("deb_glitch", 32'(seen), 0);

    // ---- debounce: long hold appears one cycle after the 4th ce tick ----
    indir_b = 4'b1000;
    step();
    ticks = 0; n = 0;
    while (ticks < 4 && n < 100) begin
      tick_now = ce_b;
      step();
      n++;
      if (tick_now) ticks++;
    end
    check("deb_tick_budget", 32'(ticks), 4);
    check("deb_before", 32'(outdir_b), 0);
    step();
    check("deb_after", 32'(outdir_b), 32'h8);
    check("deb_chg", 32'(changed_b), 1);

    // ---- randomized run against the model ----
    mode_a = 2'd1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 3) == 0) indir_a[4*c +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) mode_a = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 99) == 0);
      step();
      check("rand_out", 32'(outdir_a), 32'(m_out));
      check("rand_chg", 32'(changed_a), 32'(m_chg));
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_dir_filter.md
# joy_dir_filter

Parametrised multi-player joystick direction conditioner between the raw input merge (keyboard OR HPS joystick) and the core's IN0/IN1 port assembly. It is the successor to the single-channel 4-way filter. It adds:
- NCH independent channels
- per-bit debounce
- a runtime-selectable mode (8-way, 4-way newest-wins, 4-way oldest-holds, 2-way horizontal)
- opposing-direction neutralisation
- a per-channel change strobe

In every 4-way mode the output is guaranteed to be one-hot or zero.

## Interface
Parameters:
- NCH, 2, number of independent player channels (1..4).
- DEB_TICKS, 0, number of consecutive ce ticks a raw bit must differ from its debounced value before the debounced value follows it; 0 bypasses debounce.
- SOCD_NEUTRAL, 1, in mode 0: up+down together output neither, and left+right together output neither.

Ports (the one clock is clk; reset is synchronous and active-high, named reset):
- clk  in  1  system clock (clk_sys domain)
- reset  in  1  synchronous, active-high
- ce  in  1  debounce tick enable; ignored when DEB_TICKS=0
- mode  in  2  0=8-way pass, 1=4-way newest-wins, 2=4-way oldest-holds, 3=2-way horizontal
- indir  in  4*NCH  raw directions; channel c occupies [4c+3:4c] = {up,down,left,right}, active-high
- outdir  out  4*NCH  filtered directions, same layout, registered
- changed  out  NCH  1-cycle pulse when a channel's outdir differs from its previous value

## Operation
- **Sync stage:** sync <= indir every clk.
- **Debounce (per bit):**
  - cnt counts ce ticks while sync≠deb and resets to 0 when sync==deb.
  - deb toggles on the ce tick that brings cnt to DEB_TICKS, and cnt clears on that tick.
  - If DEB_TICKS=0: deb <= sync every clk.
- **Priority order for all one-hot selection:** up > down > left > right (bit 3 highest).
- **rise** = deb & ~deb_prev, per channel.
- **Mode 0:** out = deb. If SOCD_NEUTRAL, clear both bits of any opposing pair that are both set.
- **Mode 1 (newest wins):**
  - If rise≠0: cur <= onehot(prio(rise)).
  - Else if (cur & deb)==0: cur <= onehot(prio(deb)), or 0 if deb==0.
  - Else cur holds.
  - The release of the active direction falls back to another held direction; it never produces a diagonal.
- **Mode 2 (oldest holds):**
  - If (cur & deb)≠0: hold.
  - Else cur <= onehot(prio(deb)), or 0.
- **Mode 3:** as mode 1, with up/down masked to 0 before arbitration. Output up/down is always 0.
- **Modes 1–3:** out = cur.
- **Mode change:** mode_q registers mode. On any cycle where mode≠mode_q, cur is cleared in every channel and outdir is driven 0 on the next edge. Arbitration under the new mode starts on the following cycle.
- **changed[c]** <= (next outdir slice ≠ current outdir slice).
- Channels are fully independent; no cross-channel interaction.

## Timing
- **Reset:** sync, deb, deb_prev, cnt, cur, mode_q, outdir and changed all go to 0. The first post-reset cycle with mode≠0 is treated as a mode change, which is harmless.
- **Latency, DEB_TICKS=0:** indir change at edge k → sync at k+1 → deb at k+2 → outdir and changed at k+3 (3 cycles).
- **Latency, DEB_TICKS=N:** outdir updates 1 cycle after the clk on which deb toggles. deb toggles on the N-th ce tick counted from the edge after sync changes.
- **Glitch rejection:** a raw pulse shorter than N ce ticks never reaches deb, because cnt clears when sync returns.
- **Simultaneous rises in one cycle:** resolved by the priority order.
- **Rise and release of the active direction in the same cycle (mode 1):** the rise wins.
- **reset mid-hold:** outdir is 0 next cycle. A still-held input re-appears 3 cycles after reset deasserts.
- ce held high behaves as ce every clk.

## Structure
- Package joy_pkg holds:
  - mode constants JOY_8WAY, JOY_4NEW, JOY_4OLD, JOY_2H
  - direction bit indices DIR_UP=3, DIR_DN=2, DIR_LT=1, DIR_RT=0
  - function prio_onehot(logic [3:0]) returning a one-hot value, or 0
- Sub-module joy_debounce (WIDTH, DEB_TICKS): vector debounce with a per-bit counter of width $clog2(DEB_TICKS+1). Instantiated once with WIDTH=4*NCH.
- Per-channel arbitration is a generate loop in the top module.

## Test plan
- **Mode 1, NCH=1, DEB_TICKS=0:**
  - press left, then up 10 cycles later → outdir 4'b0010 then 4'b1000.
  - release up → 4'b0010 (no diagonal).
  - release left → 4'b0000.
  - changed pulses on each transition.
- **Mode 2:** hold right, then add up → outdir stays 4'b0001. Release right → 4'b1000 after 3 cycles.
- **Mode 0, SOCD_NEUTRAL=1:**
  - indir 4'b1110 → outdir 4'b0010.
  - indir 4'b1001 → outdir 4'b1001.
- **Mode 3:** indir 4'b1010 → outdir 4'b0010. indir 4'b1000 → outdir 4'b0000.
- **DEB_TICKS=4, ce every 4th clk:**
  - a 3-tick pulse on up never appears.
  - a 5-tick hold appears 1 cycle after the 4th ce tick.
- **Mode and reset disturbances:**
  - mode 1→0 while holding down → outdir 0 for one cycle, then 4'b0100.
  - reset asserted while holding → outdir 0; reappears 3 cycles after release of reset.
- **NCH=2:** independent presses on ch0 and ch1 in the same cycle → both slices and both changed bits update with no interaction.
